// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the division execute-stage controller.
package div_pkg;

    // Bit 2 = word (W) variant, bit 1 = remainder, bit 0 = unsigned.
    typedef enum logic [2:0] {
        DIV   = 3'd0,
        DIVU  = 3'd1,
        REM   = 3'd2,
        REMU  = 3'd3,
        DIVW  = 3'd4,
        DIVUW = 3'd5,
        REMW  = 3'd6,
        REMUW = 3'd7
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    // Cycles div_valid is held: 1 core load cycle + 65 iteration cycles.
    localparam int DIV_LAT_DEFAULT = 66;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic is_signed_op(input div_op_t op);
        logic [2:0] code;
        code = op;
        return ~code[0];
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        logic [2:0] code;
        code = op;
        return code[1];
    endfunction

    function automatic logic is_word_op(input div_op_t op);
        logic [2:0] code;
        code = op;
        return code[2];
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response handshake bundle between the execute stage and div_ctrl.
interface div_ctrl_if;
    import div_pkg::*;

    logic        in_valid;
    logic        in_ready;
    div_op_t     in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    // Requester side (execute stage / testbench).
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Controller side.
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/div_fixup.sv
// Post-processing of the unsigned core result: pick quotient or remainder,
// restore the sign, and sign-extend word results.
module div_fixup
    import div_pkg::*;
(
    input  logic [127:0] div_c,
    input  div_op_t      op,
    input  logic         neg_quo,
    input  logic         neg_rem,
    output logic [63:0]  res
);

    logic [63:0] sel;
    logic [63:0] fixed;

    // Select, negate (64-bit wrap) and narrow the core output.
    always_comb begin
        sel   = is_rem_op(op) ? div_c[127:64] : div_c[63:0];
        fixed = (is_rem_op(op) ? neg_rem : neg_quo) ? (64'd0 - sel) : sel;
        res   = is_word_op(op) ? sext32(fixed[31:0]) : fixed;
    end

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage division controller: conditions operands, sequences the external
// unsigned iterative core, resolves divide-by-zero/overflow without the core.
module div_ctrl
    import div_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    div_ctrl_if.slave      bus,
    output logic           div_valid,
    output logic [63:0]    div_a,
    output logic [63:0]    div_b,
    input  logic [127:0]   div_c
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    ctrl_state_t state_q, state_d;
    cnt_t        count_q, count_d;
    div_op_t     op_q, op_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] div_a_q, div_a_d;
    logic [63:0] div_b_q, div_b_d;
    logic [63:0] out_data_q, out_data_d;

    logic        sgn, word, sa, sb, b_zero, ovf, special;
    logic [63:0] a_w, b_w, spec_raw, spec_res, fix_res;

    div_fixup u_fixup (
        .div_c   (div_c),
        .op      (op_q),
        .neg_quo (neg_quo_q),
        .neg_rem (neg_rem_q),
        .res     (fix_res)
    );

    // Width/sign conditioning of the incoming operands and special-case detection.
    always_comb begin
        sgn  = is_signed_op(bus.in_op);
        word = is_word_op(bus.in_op);
        if (word) begin
            a_w = sgn ? sext32(bus.in_a[31:0]) : {32'd0, bus.in_a[31:0]};
            b_w = sgn ? sext32(bus.in_b[31:0]) : {32'd0, bus.in_b[31:0]};
        end else begin
            a_w = bus.in_a;
            b_w = bus.in_b;
        end
        sa      = sgn & a_w[63];
        sb      = sgn & b_w[63];
        b_zero  = (b_w == 64'd0);
        ovf     = sgn && (b_w == {64{1'b1}}) &&
                  (word ? (a_w[31:0] == 32'h8000_0000) : (a_w == 64'h8000_0000_0000_0000));
        special = b_zero | ovf;
        // Divide-by-zero: q = all ones, r = a.  Overflow: q = a, r = 0.
        if (is_rem_op(bus.in_op)) spec_raw = b_zero ? a_w : 64'd0;
        else                      spec_raw = b_zero ? {64{1'b1}} : a_w;
        spec_res = word ? sext32(spec_raw[31:0]) : spec_raw;
    end

    // FSM next state, operand capture and result capture.
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        out_data_d = out_data_q;
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_d      = bus.in_op;
                        neg_quo_d = sa ^ sb;
                        neg_rem_d = sa;
                        div_a_d   = sa ? (64'd0 - a_w) : a_w;
                        div_b_d   = sb ? (64'd0 - b_w) : b_w;
                        if (special) begin
                            out_data_d = spec_res;
                            state_d    = DONE;
                        end else begin
                            count_d = cnt_t'(DIV_LAT);
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    count_d = count_q - cnt_t'(1);
                    if (count_q == cnt_t'(1)) begin
                        out_data_d = fix_res;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and data registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= DIV;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_data_q;
    assign div_valid     = (state_q == BUSY);
    assign div_a         = div_a_q;
    assign div_b         = div_b_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a behavioural unsigned core
// that only presents a correct result in the final div_valid cycle.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int LAT = 66;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         div_valid;
    logic [63:0]  div_a;
    logic [63:0]  div_b;
    logic [127:0] div_c;

    div_ctrl_if bus ();

    div_ctrl #(.DIV_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .div_valid (div_valid),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_c     (div_c)
    );

    always #5 clk = ~clk;

    // Core model: result is final only once div_valid has been held LAT-1 edges.
    int          core_cnt   = 0;
    int          dv_cycles  = 0;
    int          unstable   = 0;
    logic [63:0] a_snap, b_snap;

    always @(posedge clk) begin
        if (div_valid) begin
            core_cnt  <= core_cnt + 1;
            dv_cycles <= dv_cycles + 1;
            if (core_cnt == 0) begin
                a_snap <= div_a;
                b_snap <= div_b;
            end else if (div_a !== a_snap || div_b !== b_snap) begin
                unstable <= unstable + 1;
            end
        end else begin
            core_cnt <= 0;
        end
    end

    always_comb begin
        div_c = {64'hDEAD_BEEF_DEAD_BEEF, 64'hBAD0_BAD0_BAD0_BAD0};
        if (div_valid && core_cnt >= LAT - 1 && div_b != 64'd0)
            div_c = {div_a % div_b, div_a / div_b};
    end

    typedef struct {
        string       name;
        logic [63:0] data;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input div_op_t op, input logic [63:0] a, input logic [63:0] b);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Issue, wait (bounded) for the result, compare against the scoreboard, release.
    task automatic run_op(input string name, input div_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        int   lat_seen;
        int   dv0;
        exp_t e;
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        dv0 = dv_cycles;
        sb_q.push_back('{name, exp, lat});
        issue(op, a, b);
        lat_seen = 1;
        while (!bus.out_valid && lat_seen < 200) begin
            @(negedge clk);
            lat_seen++;
        end
        e = sb_q.pop_front();
        check({e.name, "_lat"}, 64'(lat_seen), 64'(e.lat));
        check({e.name, "_data"}, bus.out_data, e.data);
        check({e.name, "_busy_cycles"}, 64'(dv_cycles - dv0), 64'((e.lat == 1) ? 0 : LAT));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({e.name, "_back_idle"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    endtask

    logic        ov_seen, dv_seen;
    logic [63:0] held;
    int          waited;

    initial begin
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = DIVU;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_div_valid", 64'(div_valid), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // out_ready with nothing pending is ignored.
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_out_ready_ignored", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);

        run_op("divu_100_7", DIVU, 64'd100, 64'd7, 64'd14, LAT + 1);
        run_op("remu_100_7", REMU, 64'd100, 64'd7, 64'd2, LAT + 1);
        run_op("div_m100_7", DIV, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, LAT + 1);
        run_op("rem_m100_7", REM, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, LAT + 1);
        run_op("div_100_m7", DIV, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, LAT + 1);
        run_op("rem_100_m7", REM, 64'd100, -64'sd7, 64'd2, LAT + 1);
        run_op("div_by_zero", DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem_by_zero", REM, 64'd5, 64'd0, 64'd5, 1);
        run_op("remw_low_zero", REMW, 64'h1_8000_0005, 64'h1_0000_0000,
               64'hFFFF_FFFF_8000_0005, 1);
        run_op("div_ovf", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("divw_ovf", DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divw_lowwords", DIVW, 64'h1_0000_0010, 64'hFFFF_FFFF_FFFF_FFFC,
               64'hFFFF_FFFF_FFFF_FFFC, LAT + 1);
        run_op("remuw_ffff_2", REMUW, 64'hFFFF_FFFF, 64'd2, 64'd1, LAT + 1);
        run_op("divuw_sext", DIVUW, 64'hABCD_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, LAT + 1);

        // Flush while BUSY with count=30 (36 edges after accept); a same-cycle request is dropped.
        issue(DIVU, 64'd1000, 64'd3);
        repeat (36) @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = DIVU;
        bus.in_a     = 64'd50;
        bus.in_b     = 64'd5;
        @(posedge clk);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_div_valid", 64'(div_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        ov_seen = 1'b0;
        dv_seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            ov_seen |= bus.out_valid;
            dv_seen |= div_valid;
        end
        check("flush_no_result", 64'(ov_seen), 64'd0);
        check("flush_no_restart", 64'(dv_seen), 64'd0);
        run_op("divu_9_3_after_flush", DIVU, 64'd9, 64'd3, 64'd3, LAT + 1);

        // Back-pressure: result held stable while out_ready stays low.
        sb_q.push_back('{"backpressure", 64'd100, LAT + 1});
        issue(DIVU, 64'd1000, 64'd10);
        waited = 1;
        while (!bus.out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, "_lat"}, 64'(waited), 64'(e.lat));
            check({e.name, "_data"}, bus.out_data, e.data);
            held = e.data;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", bus.out_data, held);
            check("bp_hold_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'b01);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);

        // Reset mid-operation returns everything to reset values.
        issue(DIVU, 64'd77, 64'd7);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_div_valid", 64'(div_valid), 64'd0);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_data", bus.out_data, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        run_op("divu_77_7_after_reset", DIVU, 64'd77, 64'd7, 64'd11, LAT + 1);

        check("core_operands_stable", 64'(unstable), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
